// File: rtl/md_sched_pkg.sv
// rtl/md_sched_pkg.sv - shared encodings and defaults for the MDU scheduler
package md_sched_pkg;

   typedef enum logic [1:0] {
      MD_MULT  = 2'd0,
      MD_MULTU = 2'd1,
      MD_DIV   = 2'd2,
      MD_DIVU  = 2'd3
   } md_op_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } md_state_e;

   localparam logic MT_LO = 1'b0;
   localparam logic MT_HI = 1'b1;

   localparam int MULT_CYCLES_DEF = 5;
   localparam int DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/md_arith.sv
// rtl/md_arith.sv - combinational multiply/divide datapath producing HI/LO
module md_arith
   import md_sched_pkg::*;
(
   input  md_op_e      i_op,
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   output logic [31:0] o_hi,
   output logic [31:0] o_lo,
   output logic        o_div0
);

   logic [63:0] w_prod_s;
   logic [63:0] w_prod_u;
   logic [31:0] w_ua;
   logic [31:0] w_ub;
   logic [31:0] w_uq;
   logic [31:0] w_ur;
   logic        w_signed_div;

   assign w_prod_s = {{32{i_a[31]}}, i_a} * {{32{i_b[31]}}, i_b};
   assign w_prod_u = {32'd0, i_a} * {32'd0, i_b};

   // Signed divide works on magnitudes so that 0x80000000 / -1 wraps cleanly
   // and the divisor is forced nonzero to keep the divider well defined.
   always_comb begin
      w_signed_div = (i_op == MD_DIV);
      w_ua = (w_signed_div && i_a[31]) ? (32'd0 - i_a) : i_a;
      w_ub = (w_signed_div && i_b[31]) ? (32'd0 - i_b) : i_b;
      if (w_ub == 32'd0) begin
         w_ub = 32'd1;
      end
      w_uq = w_ua / w_ub;
      w_ur = w_ua % w_ub;
   end

   // Select the result pair for the requested operation.
   always_comb begin
      o_hi   = 32'd0;
      o_lo   = 32'd0;
      o_div0 = 1'b0;
      case (i_op)
         MD_MULT: begin
            o_hi = w_prod_s[63:32];
            o_lo = w_prod_s[31:0];
         end
         MD_MULTU: begin
            o_hi = w_prod_u[63:32];
            o_lo = w_prod_u[31:0];
         end
         MD_DIV: begin
            o_lo   = (i_a[31] ^ i_b[31]) ? (32'd0 - w_uq) : w_uq;
            o_hi   = i_a[31] ? (32'd0 - w_ur) : w_ur;
            o_div0 = (i_b == 32'd0);
         end
         default: begin
            o_lo   = w_uq;
            o_hi   = w_ur;
            o_div0 = (i_b == 32'd0);
         end
      endcase
   end

endmodule

// File: rtl/md_sched.sv
// rtl/md_sched.sv - multi-cycle mult/div scheduler with HI/LO register file
module md_sched
   import md_sched_pkg::*;
#(
   parameter int MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = DIV_CYCLES_DEF
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        md_start,
   input  logic [1:0]  md_op,
   input  logic        mt_we,
   input  logic        mt_sel,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        D_md_use,
   output logic        busy,
   output logic [31:0] HI,
   output logic [31:0] LO,
   output logic        stall_req
);

   md_state_e   r_state;
   md_state_e   w_state_nxt;
   logic [3:0]  r_cnt;
   logic [31:0] r_pend_hi;
   logic [31:0] r_pend_lo;
   logic        r_pend_div0;
   logic [31:0] r_hi;
   logic [31:0] r_lo;

   logic [31:0] w_ar_hi;
   logic [31:0] w_ar_lo;
   logic        w_ar_div0;
   logic        w_idle;
   logic        w_start;
   logic        w_mt;
   logic        w_commit;
   logic [3:0]  w_cnt_load;

   md_arith u_arith (
      .i_op   (md_op_e'(md_op)),
      .i_a    (A),
      .i_b    (B),
      .o_hi   (w_ar_hi),
      .o_lo   (w_ar_lo),
      .o_div0 (w_ar_div0)
   );

   // Issue and mt writes are only honoured in IDLE; an issue beats an mt write.
   assign w_idle     = (r_state == ST_IDLE);
   assign w_start    = md_start & w_idle;
   assign w_mt       = mt_we & w_idle & ~md_start;
   assign w_commit   = (r_state == ST_RUN) & (r_cnt == 4'd1);
   assign w_cnt_load = md_op[1] ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);

   assign busy      = (r_state == ST_RUN);
   assign HI        = r_hi;
   assign LO        = r_lo;
   assign stall_req = D_md_use & (busy | md_start);

   // Next-state: leave IDLE on an issue, return when the counter expires.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (md_start) w_state_nxt = ST_RUN;
         ST_RUN:  if (r_cnt == 4'd1) w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Latency counter and pending result captured at issue.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt       <= 4'd0;
         r_pend_hi   <= 32'd0;
         r_pend_lo   <= 32'd0;
         r_pend_div0 <= 1'b0;
      end else if (w_start) begin
         r_cnt       <= w_cnt_load;
         r_pend_hi   <= w_ar_hi;
         r_pend_lo   <= w_ar_lo;
         r_pend_div0 <= w_ar_div0;
      end else if (r_state == ST_RUN) begin
         r_cnt <= r_cnt - 4'd1;
      end
   end

   // HI/LO: committed results (skipped on divide by zero) and mthi/mtlo writes.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_hi <= 32'd0;
         r_lo <= 32'd0;
      end else if (w_commit) begin
         if (!r_pend_div0) begin
            r_hi <= r_pend_hi;
            r_lo <= r_pend_lo;
         end
      end else if (w_mt) begin
         if (mt_sel == MT_HI) r_hi <= A;
         else                 r_lo <= A;
      end
   end

endmodule

// File: tb/tb_md_sched.sv
// tb/tb_md_sched.sv - directed scoreboard bench for md_sched
module tb_md_sched;
   import md_sched_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        md_start;
   logic [1:0]  md_op;
   logic        mt_we;
   logic        mt_sel;
   logic [31:0] A;
   logic [31:0] B;
   logic        D_md_use;
   logic        busy;
   logic [31:0] HI;
   logic [31:0] LO;
   logic        stall_req;

   int n_vec = 0;
   int n_err = 0;
   logic [31:0] m_hi = 32'd0;
   logic [31:0] m_lo = 32'd0;
   logic [63:0] sb_q[$];

   md_sched dut (
      .clk(clk), .reset(reset), .md_start(md_start), .md_op(md_op),
      .mt_we(mt_we), .mt_sel(mt_sel), .A(A), .B(B), .D_md_use(D_md_use),
      .busy(busy), .HI(HI), .LO(LO), .stall_req(stall_req)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference result for one operation; divide by zero keeps the model HI/LO.
   function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, q, r, p;
      longint unsigned ua, ub, up;
      logic [63:0] res;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      res = 64'd0;
      case (op)
         2'd0: begin p = sa * sb; res = p; end
         2'd1: begin up = ua * ub; res = up; end
         2'd2: begin
            if (b == 32'd0) res = {m_hi, m_lo};
            else begin
               q = sa / sb;
               r = sa % sb;
               res = {r[31:0], q[31:0]};
            end
         end
         default: begin
            if (b == 32'd0) res = {m_hi, m_lo};
            else begin
               up = ua / ub;
               res[31:0] = up[31:0];
               up = ua % ub;
               res[63:32] = up[31:0];
            end
         end
      endcase
      return res;
   endfunction

   // Issue one op, push its expected result, follow busy to commit and compare.
   task automatic issue(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic dmu, input logic mt_same,
                        input logic mt_busy);
      int n_exp;
      int cnt;
      logic [63:0] exp;
      n_exp = op[1] ? 10 : 5;
      sb_q.push_back(model(op, a, b));
      md_start = 1'b1; md_op = op; A = a; B = b; D_md_use = dmu;
      mt_we = mt_same; mt_sel = MT_HI;
      #3;
      check({tag, "_stall_t0"}, {63'd0, stall_req}, {63'd0, dmu});
      step();
      md_start = 1'b0; mt_we = 1'b0;
      cnt = 0;
      while (busy === 1'b1 && cnt < 40) begin
         cnt++;
         if (cnt == 2) begin
            check({tag, "_stall_busy"}, {63'd0, stall_req}, {63'd0, dmu});
            check({tag, "_hold"}, {HI, LO}, {m_hi, m_lo});
            if (mt_busy) begin
               mt_we = 1'b1; mt_sel = MT_HI; A = 32'hDEAD_BEEF;
            end
         end else begin
            mt_we = 1'b0;
         end
         step();
      end
      mt_we = 1'b0;
      check({tag, "_busy_cycles"}, 64'(cnt), 64'(n_exp));
      exp = sb_q.pop_front();
      check({tag, "_hilo"}, {HI, LO}, exp);
      check({tag, "_stall_done"}, {63'd0, stall_req}, 64'd0);
      m_hi = exp[63:32];
      m_lo = exp[31:0];
      D_md_use = 1'b0;
   endtask

   task automatic mt_write(input logic sel, input logic [31:0] val);
      mt_we = 1'b1; mt_sel = sel; A = val;
      step();
      mt_we = 1'b0;
      if (sel == MT_HI) m_hi = val;
      else              m_lo = val;
      check("mt_write", {HI, LO}, {m_hi, m_lo});
   endtask

   initial begin
      reset = 1'b1; md_start = 1'b0; md_op = 2'd0; mt_we = 1'b0; mt_sel = 1'b0;
      A = 32'd0; B = 32'd0; D_md_use = 1'b0;
      step(); step();
      reset = 1'b0;
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_hilo", {HI, LO}, 64'd0);
      check("rst_stall", {63'd0, stall_req}, 64'd0);

      issue("mult", 2'd0, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0, 1'b0);
      issue("multu", 2'd1, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0, 1'b0);
      issue("div", 2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, 1'b0);
      issue("divu", 2'd3, 32'd7, 32'd2, 1'b0, 1'b0, 1'b0);
      issue("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);

      mt_write(MT_HI, 32'h11);
      mt_write(MT_LO, 32'h22);
      issue("div0", 2'd2, 32'd100, 32'd0, 1'b0, 1'b0, 1'b0);
      issue("divu0", 2'd3, 32'd5, 32'd0, 1'b0, 1'b0, 1'b0);

      issue("stall", 2'd0, 32'd12345, 32'd678, 1'b1, 1'b0, 1'b1);
      issue("start_mt", 2'd1, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b1, 1'b0);
      issue("div_neg", 2'd2, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);

      md_start = 1'b1; md_op = 2'd2; A = 32'hFFFF_FFF9; B = 32'd2;
      step();
      md_start = 1'b0;
      step(); step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      m_hi = 32'd0; m_lo = 32'd0;
      check("abort_busy", {63'd0, busy}, 64'd0);
      check("abort_hilo", {HI, LO}, 64'd0);
      step();
      check("abort_stays_idle", {63'd0, busy}, 64'd0);

      issue("mult_after_rst", 2'd0, 32'd40000, 32'hFFFF_FFF0, 1'b0, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
